multiplier_sequencer: RTL and testbench



---
 rtl/multiplier_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_multiplier_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: steps one multiplier through write-in, read-in, write-out, read-out; aborts on access error.
// Latency: accept to resultValid is 4*STAGE_CYCLES cycles; an aborted request reaches resultValid one cycle after the error.
// Backpressure: startReady only in IDLE; the result is held in HOLD until resultReady. MUL_SEQ_PERF_EN adds opCount/errCount.
module multiplier_sequencer #(
    parameter int N            = 32,
    parameter int STAGE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startValid,
    output logic             startReady,
    input  logic [N-1:0]     opA,
    input  logic [N-1:0]     opB,
    output logic             resultValid,
    input  logic             resultReady,
    output logic [2*N-1:0]   result,
    output logic             resultOverflow,
    output logic             resultError,
    output logic [N-1:0]     mulA,
    output logic [N-1:0]     mulB,
    output logic             writeEnableA,
    output logic             writeEnableB,
    output logic             readEnableA,
    output logic             readEnableB,
    output logic             writeEnableOut,
    output logic             readEnableOut,
    output logic             resetA,
    output logic             resetB,
    output logic             resetOut,
    input  logic             accessErrorA,
    input  logic             accessErrorB,
    input  logic             accessErrorOut,
    input  logic [2*N-1:0]   mulProduct,
    input  logic             mulOverflow
`ifdef MUL_SEQ_PERF_EN
    ,
    output logic [31:0]      opCount,
    output logic [15:0]      errCount
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR_IN,
        RD_IN,
        WR_OUT,
        RD_OUT,
        ABORT,
        HOLD
    } state_t;

    // A single-cycle stage still needs a 1-bit counter so the compare below stays well formed.
    localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   stage_cnt;
    logic            stage_last;
    logic            in_phase;
    logic            any_err;
    logic            abort_now;

    assign stage_last = (stage_cnt == STAGE_LAST);
    assign in_phase   = (state == WR_IN) || (state == RD_IN) ||
                        (state == WR_OUT) || (state == RD_OUT);
    assign any_err    = accessErrorA | accessErrorB | accessErrorOut;
    // Errors only matter while the multiplier is being driven; IDLE/HOLD ignore them.
    assign abort_now  = in_phase && any_err;

    // Next-state and Moore outputs; enables are one-hot per phase so a read and a write never overlap.
    always_comb begin
        state_nxt      = state;
        startReady     = 1'b0;
        resultValid    = 1'b0;
        writeEnableA   = 1'b0;
        writeEnableB   = 1'b0;
        readEnableA    = 1'b0;
        readEnableB    = 1'b0;
        writeEnableOut = 1'b0;
        readEnableOut  = 1'b0;
        resetA         = 1'b0;
        resetB         = 1'b0;
        resetOut       = 1'b0;
        unique case (state)
            IDLE: begin
                startReady = 1'b1;
                if (startValid) state_nxt = WR_IN;
            end
            WR_IN: begin
                writeEnableA = 1'b1;
                writeEnableB = 1'b1;
                if (any_err)         state_nxt = ABORT;
                else if (stage_last) state_nxt = RD_IN;
            end
            RD_IN: begin
                readEnableA = 1'b1;
                readEnableB = 1'b1;
                if (any_err)         state_nxt = ABORT;
                else if (stage_last) state_nxt = WR_OUT;
            end
            WR_OUT: begin
                writeEnableOut = 1'b1;
                if (any_err)         state_nxt = ABORT;
                else if (stage_last) state_nxt = RD_OUT;
            end
            RD_OUT: begin
                readEnableOut = 1'b1;
                // An error on the final read cycle wins over completion.
                if (any_err)         state_nxt = ABORT;
                else if (stage_last) state_nxt = HOLD;
            end
            ABORT: begin
                resetA    = 1'b1;
                resetB    = 1'b1;
                resetOut  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                resultValid = 1'b1;
                if (resultReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nxt;
    end

    // Stage counter: runs within a phase, restarts whenever the phase ends or is aborted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                              stage_cnt <= '0;
        else if (in_phase && !stage_last && !any_err) stage_cnt <= stage_cnt + 1'b1;
        else                                      stage_cnt <= '0;
    end

    // Operand latch: held stable from accept until the next accept.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mulA <= '0;
            mulB <= '0;
        end else if (state == IDLE && startValid) begin
            mulA <= opA;
            mulB <= opB;
        end
    end

    // Result capture: product on clean completion, zeros plus error flag after an abort.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            result         <= '0;
            resultOverflow <= 1'b0;
            resultError    <= 1'b0;
        end else if (state == RD_OUT && stage_last && !any_err) begin
            result         <= mulProduct;
            resultOverflow <= mulOverflow;
            resultError    <= 1'b0;
        end else if (state == ABORT) begin
            result         <= '0;
            resultOverflow <= 1'b0;
            resultError    <= 1'b1;
        end
    end

`ifdef MUL_SEQ_PERF_EN
    // Performance counters: good handshakes wrap, abort entries saturate.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            opCount  <= '0;
            errCount <= '0;
        end else begin
            if (state == HOLD && resultReady && !resultError) opCount <= opCount + 32'd1;
            if (abort_now && errCount != 16'hFFFF)            errCount <= errCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_sequencer.sv
// tb_multiplier_sequencer: two sequencers (STAGE_CYCLES 1 and 3) against a transaction-level model.
// Each sequencer drives a small behavioural multiplier whose product is only visible during its read enable.
// Outputs are compared every falling edge; inputs change 2 time units after the rising edge.
module tb_multiplier_sequencer;

    logic clk;
    logic resetN;

    logic [1:0]        start_valid;
    logic [1:0]        start_ready;
    logic [1:0][31:0]  op_a;
    logic [1:0][31:0]  op_b;
    logic [1:0]        result_valid;
    logic [1:0]        result_ready;
    logic [1:0][63:0]  result;
    logic [1:0]        result_ovf;
    logic [1:0]        result_err;
    logic [1:0][31:0]  mul_a;
    logic [1:0][31:0]  mul_b;
    logic [1:0]        we_a, we_b, re_a, re_b, we_out, re_out;
    logic [1:0]        rst_a, rst_b, rst_out;
    logic [1:0][2:0]   acc_err;
`ifdef MUL_SEQ_PERF_EN
    logic [1:0][31:0]  op_count;
    logic [1:0][15:0]  err_count;
`endif

    int checks;
    int errors;
    int tmo_cnt;
    int tmo_seen;

    bit          lit_on [2];
    logic [63:0] lit_res[2];
    bit          lit_err[2];
    bit          perf_lit;

    // Transaction-level model state.
    bit          m_busy [2];
    int          m_t    [2];
    bit          m_abort[2];
    bit          m_hold [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [63:0] m_res  [2];
    bit          m_ovf  [2];
    bit          m_err  [2];
    logic [31:0] m_opc  [2];
    logic [15:0] m_errc [2];

    function automatic int stg(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic bit ovf_of(input logic [63:0] p);
        return !((p[63:31] == '0) || (p[63:31] == '1));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] fm_a;
        logic [31:0] fm_b;
        logic [63:0] fm_p;
        logic        fm_o;

        // Behavioural multiplier: input registers, then product register written from them.
        always @(posedge clk) begin
            if (rst_a[g])     fm_a <= '0;
            else if (we_a[g]) fm_a <= mul_a[g];
            if (rst_b[g])     fm_b <= '0;
            else if (we_b[g]) fm_b <= mul_b[g];
            if (rst_out[g]) begin
                fm_p <= '0;
                fm_o <= 1'b0;
            end else if (we_out[g]) begin
                fm_p <= smul(fm_a, fm_b);
                fm_o <= ovf_of(smul(fm_a, fm_b));
            end
        end

        multiplier_sequencer #(.N(32), .STAGE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .resetN         (resetN),
            .startValid     (start_valid[g]),
            .startReady     (start_ready[g]),
            .opA            (op_a[g]),
            .opB            (op_b[g]),
            .resultValid    (result_valid[g]),
            .resultReady    (result_ready[g]),
            .result         (result[g]),
            .resultOverflow (result_ovf[g]),
            .resultError    (result_err[g]),
            .mulA           (mul_a[g]),
            .mulB           (mul_b[g]),
            .writeEnableA   (we_a[g]),
            .writeEnableB   (we_b[g]),
            .readEnableA    (re_a[g]),
            .readEnableB    (re_b[g]),
            .writeEnableOut (we_out[g]),
            .readEnableOut  (re_out[g]),
            .resetA         (rst_a[g]),
            .resetB         (rst_b[g]),
            .resetOut       (rst_out[g]),
            .accessErrorA   (acc_err[g][0]),
            .accessErrorB   (acc_err[g][1]),
            .accessErrorOut (acc_err[g][2]),
            .mulProduct     (re_out[g] ? fm_p : 64'hDEAD_BEEF_0BAD_F00D),
            .mulOverflow    (re_out[g] ? fm_o : 1'b1)
`ifdef MUL_SEQ_PERF_EN
            ,
            .opCount        (op_count[g]),
            .errCount       (err_count[g])
`endif
        );
    end

    // Model: busy for 4*S cycles after accept (phase = elapsed / S), one abort cycle on error, then hold.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0; m_t[i] <= 0; m_abort[i] <= 1'b0; m_hold[i] <= 1'b0;
                m_a[i] <= '0; m_b[i] <= '0; m_res[i] <= '0; m_ovf[i] <= 1'b0; m_err[i] <= 1'b0;
                m_opc[i] <= '0; m_errc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (acc_err[i] != 3'b000) begin
                        m_busy[i]  <= 1'b0;
                        m_abort[i] <= 1'b1;
                        if (m_errc[i] != 16'hFFFF) m_errc[i] <= m_errc[i] + 16'd1;
                    end else if (m_t[i] == 4 * stg(i) - 1) begin
                        m_busy[i] <= 1'b0;
                        m_hold[i] <= 1'b1;
                        m_res[i]  <= smul(m_a[i], m_b[i]);
                        m_ovf[i]  <= ovf_of(smul(m_a[i], m_b[i]));
                        m_err[i]  <= 1'b0;
                    end else begin
                        m_t[i] <= m_t[i] + 1;
                    end
                end else if (m_abort[i]) begin
                    m_abort[i] <= 1'b0;
                    m_hold[i]  <= 1'b1;
                    m_res[i]   <= '0;
                    m_ovf[i]   <= 1'b0;
                    m_err[i]   <= 1'b1;
                end else if (m_hold[i]) begin
                    if (result_ready[i]) begin
                        m_hold[i] <= 1'b0;
                        if (!m_err[i]) m_opc[i] <= m_opc[i] + 32'd1;
                    end
                end else if (start_valid[i]) begin
                    m_busy[i] <= 1'b1;
                    m_t[i]    <= 0;
                    m_a[i]    <= op_a[i];
                    m_b[i]    <= op_b[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Single compare process: all DUT outputs against the model, every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("start_ready",  i, 64'(start_ready[i]),  64'(!m_busy[i] && !m_abort[i] && !m_hold[i]));
            chk("result_valid", i, 64'(result_valid[i]), 64'(m_hold[i]));
            chk("we_a",   i, 64'(we_a[i]),   64'(m_busy[i] && (m_t[i] / stg(i)) == 0));
            chk("we_b",   i, 64'(we_b[i]),   64'(m_busy[i] && (m_t[i] / stg(i)) == 0));
            chk("re_a",   i, 64'(re_a[i]),   64'(m_busy[i] && (m_t[i] / stg(i)) == 1));
            chk("re_b",   i, 64'(re_b[i]),   64'(m_busy[i] && (m_t[i] / stg(i)) == 1));
            chk("we_out", i, 64'(we_out[i]), 64'(m_busy[i] && (m_t[i] / stg(i)) == 2));
            chk("re_out", i, 64'(re_out[i]), 64'(m_busy[i] && (m_t[i] / stg(i)) == 3));
            chk("resets", i, 64'({rst_a[i], rst_b[i], rst_out[i]}), m_abort[i] ? 64'd7 : 64'd0);
            chk("mul_a",  i, 64'(mul_a[i]),  64'(m_a[i]));
            chk("mul_b",  i, 64'(mul_b[i]),  64'(m_b[i]));
            chk("result", i, result[i], m_res[i]);
            chk("result_ovf", i, 64'(result_ovf[i]), 64'(m_ovf[i]));
            chk("result_err", i, 64'(result_err[i]), 64'(m_err[i]));
`ifdef MUL_SEQ_PERF_EN
            chk("op_count",  i, 64'(op_count[i]),  64'(m_opc[i]));
            chk("err_count", i, 64'(err_count[i]), 64'(m_errc[i]));
`endif
            if (lit_on[i] && m_hold[i]) begin
                chk("lit_result", i, result[i], lit_res[i]);
                chk("lit_model",  i, m_res[i],  lit_res[i]);
                chk("lit_error",  i, 64'(result_err[i]), 64'(lit_err[i]));
            end
        end
`ifdef MUL_SEQ_PERF_EN
        if (perf_lit) begin
            chk("lit_op_count",  0, 64'(op_count[0]),  64'd3);
            chk("lit_err_count", 0, 64'(err_count[0]), 64'd1);
        end
`endif
        if (tmo_cnt != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout handshake_waits_expired=%0d required=%0d", tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
    end

    task automatic accept(input int i, input logic [31:0] a, input logic [31:0] b, output bit ok);
        bit r;
        op_a[i] = a;
        op_b[i] = b;
        start_valid[i] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            r = start_ready[i];
            @(posedge clk);
            #2;
            if (r) ok = 1'b1;
        end
        start_valid[i] = 1'b0;
        if (!ok) tmo_cnt++;
    endtask

    task automatic finish(input int i, input int hold, input bit rnd);
        bit hs;
        bit v;
        int seen;
        hs = 1'b0;
        seen = 0;
        result_ready[i] = rnd ? 1'($urandom_range(0, 1)) : (hold == 0);
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            v = result_valid[i];
            if (v && result_ready[i]) hs = 1'b1;
            else if (v)               seen++;
            @(posedge clk);
            #2;
            if (hs) begin
                result_ready[i] = 1'b0;
                start_valid[i]  = 1'b0;
                acc_err[i]      = 3'b000;
            end else begin
                if (v) result_ready[i] = (seen >= hold) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
                else   result_ready[i] = rnd ? 1'($urandom_range(0, 1)) : (hold == 0);
                if (rnd) begin
                    // Requests and error flags while busy/holding must all be ignored.
                    start_valid[i] = 1'($urandom_range(0, 1));
                    op_a[i] = $urandom;
                    op_b[i] = $urandom;
                    acc_err[i] = v ? 3'($urandom_range(0, 7)) : 3'b000;
                end
            end
        end
        if (!hs) tmo_cnt++;
    endtask

    task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] emask, input int ecyc, input int hold, input bit rnd);
        bit ok;
        accept(i, a, b, ok);
        result_ready[i] = 1'b0;
        if (ok && emask != 3'b000) begin
            repeat (ecyc) begin
                @(posedge clk);
                #2;
            end
            acc_err[i] = emask;
            @(posedge clk);
            #2;
            acc_err[i] = 3'b000;
        end
        if (ok) finish(i, hold, rnd);
    endtask

    task automatic lit_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] emask, input int ecyc, input int hold,
                          input logic [63:0] exp_res, input bit exp_err);
        lit_res[i] = exp_res;
        lit_err[i] = exp_err;
        lit_on[i]  = 1'b1;
        do_op(i, a, b, emask, ecyc, hold, 1'b0);
        lit_on[i]  = 1'b0;
    endtask

    task automatic rand_op(input int i);
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  em;
        a  = pick();
        b  = pick();
        em = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        do_op(i, a, b, em, $urandom_range(0, 4 * stg(i) - 1), $urandom_range(0, 3), 1'b1);
    endtask

    initial begin
        bit ok;
        checks = 0; errors = 0; tmo_cnt = 0; tmo_seen = 0; perf_lit = 1'b0;
        resetN = 1'b0;
        start_valid = '0; result_ready = '0; acc_err = '0; op_a = '0; op_b = '0;
        for (int i = 0; i < 2; i++) begin
            lit_on[i] = 1'b0; lit_res[i] = '0; lit_err[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2 resetN = 1'b1;

        // Reset while sequencer 0 is in WR_OUT: enables drop at once, nothing is presented.
        accept(0, 32'd7, 32'd9, ok);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        resetN = 1'b0;
        @(posedge clk);
        #2 resetN = 1'b1;
        lit_op(0, 32'd0, 32'd0, 3'b000, 0, 0, 64'd0, 1'b0);

        lit_op(0, 32'd211819911, 32'd12345, 3'b000, 0, 0, 64'd2614916801295, 1'b0);
        lit_op(0, -32'sd2111, 32'd125, 3'b000, 0, 5, -64'sd263875, 1'b0);
        lit_op(0, 32'd5, 32'd6, 3'b010, 1, 0, 64'd0, 1'b1);

        perf_lit = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 perf_lit = 1'b0;

        // Error coinciding with the final RD_OUT cycle discards the product.
        lit_op(0, 32'd3, 32'd4, 3'b100, 3, 1, 64'd0, 1'b1);

        lit_op(1, 32'd32, 32'd23, 3'b000, 0, 0, 64'd736, 1'b0);
        lit_op(1, 32'd100, 32'd100, 3'b001, 11, 2, 64'd0, 1'b1);
        lit_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 0, 1, 64'd1, 1'b0);

        for (int n = 0; n < 300; n++) rand_op(n % 2);

        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
